// File: rtl/hazard_pkg.sv
// Shared constants for the hazard controller: FSM encoding, default sizing
// and scoreboard counter width.
package hazard_pkg;
    localparam logic [1:0] RUN    = 2'b00;
    localparam logic [1:0] DRAIN  = 2'b01;
    localparam logic [1:0] HALTED = 2'b10;

    localparam int NREG_DEF    = 8;
    localparam int WB_DIST_DEF = 3;
    localparam int CNT_W       = $clog2(WB_DIST_DEF + 1);
endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write countdown. A load reloads the full write-back
// distance (overriding any decrement); freeze holds every counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int WB_DIST = WB_DIST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            freeze,
    input  logic            load_en,
    input  logic [2:0]      load_idx,
    output logic [NREG-1:0] pend_vec
);
    localparam int CW = $clog2(WB_DIST + 1);

    logic [NREG-1:0][CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!freeze) begin
            for (int r = 0; r < NREG; r++) begin
                if (load_en && (load_idx == 3'(r)))
                    r_cnt[r] <= CW'(WB_DIST);
                else if (r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - CW'(1);
            end
        end
    end

    always_comb begin
        pend_vec = '0;
        for (int r = 0; r < NREG; r++)
            pend_vec[r] = (r_cnt[r] != '0);
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side sequencing: RAW stall, taken-branch squash, memory freeze and
// HALT drain. Optional perf counters enabled by HAZ_PERF_CNT_EN.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREG    = NREG_DEF,
    parameter int WB_DIST = WB_DIST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [2:0]      id_rs,
    input  logic            id_rs_used,
    input  logic [2:0]      id_rt,
    input  logic            id_rt_used,
    input  logic [2:0]      id_rd,
    input  logic            id_reg_wrt,
    input  logic            id_halt,
    input  logic            ex_br_taken,
    input  logic            mem_busy,
    output logic            stall,
    output logic            bubble,
    output logic            flush,
    output logic            halted,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0]     stall_cycles,
    output logic [15:0]     flush_count,
`endif
    output logic [NREG-1:0] pend_vec
);
    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_hazard;
    logic       w_issue;

    assign w_hazard = id_valid & ((id_rs_used & pend_vec[id_rs]) |
                                  (id_rt_used & pend_vec[id_rt]));
    assign w_issue  = (r_state == RUN) & ~mem_busy & ~ex_br_taken & ~w_hazard &
                      id_valid & ~id_halt;

    hazard_scoreboard #(.NREG(NREG), .WB_DIST(WB_DIST)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .freeze   (mem_busy),
        .load_en  (w_issue & id_reg_wrt),
        .load_idx (id_rd),
        .pend_vec (pend_vec)
    );

    always_comb begin
        stall  = 1'b0;
        bubble = 1'b0;
        flush  = 1'b0;
        halted = 1'b0;
        w_next = r_state;
        if (!rst) begin
            case (r_state)
                RUN: begin
                    if (mem_busy) begin
                        stall = 1'b1;
                    end else if (ex_br_taken) begin
                        flush  = 1'b1;
                        bubble = 1'b1;
                    end else if (w_hazard) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                    end else if (id_halt) begin
                        stall  = 1'b1;
                        bubble = 1'b1;
                        w_next = DRAIN;
                    end
                end
                DRAIN: begin
                    // Memory stall still freezes ID/EX; otherwise feed bubbles until writes retire
                    stall  = 1'b1;
                    bubble = ~mem_busy;
                    if (!mem_busy && (pend_vec == '0))
                        w_next = HALTED;
                end
                default: begin
                    halted = 1'b1;
                    stall  = 1'b1;
                    bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_next;
    end

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (stall && (r_state == RUN) && (r_stall_cycles != 16'hFFFF))
                r_stall_cycles <= r_stall_cycles + 16'd1;
            if (flush && (r_flush_count != 16'hFFFF))
                r_flush_count <= r_flush_count + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif
endmodule
